// File: rtl/skinny_pkg.sv
// Shared constants and FSM encoding for the SKINNY-128-384 round controller.
// Imported by the controller and its round-constant LFSR.
package skinny_pkg;

    localparam int NUM_ROUNDS = 56;
    localparam int RC_W       = 6;
    localparam int IDX_W      = 6;

    localparam logic [5:0] RC_INIT = 6'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/skinny_rc_lfsr.sv
// Round-constant LFSR: update is {rc[4:0], rc[5]^rc[4]^1}.
// Clear has priority over enable so the controller can zero it while idle.
module skinny_rc_lfsr #(
    parameter int RC_W = skinny_pkg::RC_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    output logic [RC_W-1:0] rc
);
    import skinny_pkg::*;

    logic [RC_W-1:0] rc_q;
    logic            feedback;

    assign feedback = rc_q[RC_W-1] ^ rc_q[RC_W-2] ^ 1'b1;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rc_q <= RC_W'(RC_INIT);
        end else if (clear) begin
            rc_q <= RC_W'(RC_INIT);
        end else if (enable) begin
            rc_q <= {rc_q[RC_W-2:0], feedback};
        end
    end

    assign rc = rc_q;

endmodule

// File: rtl/skinny_round_ctrl.sv
// Round sequencer for SKINNY-128-384: LOAD for one cycle, NUM_ROUNDS stallable
// rounds, then DONE holding valid until the consumer acknowledges.
module skinny_round_ctrl #(
    parameter int NUM_ROUNDS = skinny_pkg::NUM_ROUNDS,
    parameter int RC_W       = skinny_pkg::RC_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            hold,
    input  logic            ack,
    output logic            load,
    output logic            round_en,
    output logic            tk_en,
    output logic [RC_W-1:0] rc,
    output logic [5:0]      round_idx,
    output logic            last_round,
    output logic            busy,
    output logic            valid
);
    import skinny_pkg::*;

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

    state_t     state;
    state_t     state_next;
    logic [5:0] idx_q;
    logic       rc_clear;
    logic       rc_enable;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        round_en   = 1'b0;
        busy       = 1'b0;
        valid      = 1'b0;
        last_round = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                load       = 1'b1;
                busy       = 1'b1;
                state_next = ROUND;
            end
            ROUND: begin
                busy       = 1'b1;
                round_en   = !hold;
                last_round = round_en && (idx_q == LAST_IDX);
                if (last_round) state_next = DONE;
            end
            DONE: begin
                valid = 1'b1;
                // A start coinciding with ack is dropped; only IDLE accepts start.
                if (ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign tk_en = round_en;

    // The index parks on the final round in DONE and never wraps within a run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q <= 6'd0;
        end else begin
            unique case (state)
                ROUND: if (round_en && !last_round) idx_q <= idx_q + 6'd1;
                DONE:  if (ack) idx_q <= 6'd0;
                default: idx_q <= 6'd0;
            endcase
        end
    end

    assign round_idx = idx_q;

    // Zeroed while idle so LOAD presents 0; the LOAD edge yields round 0's constant.
    assign rc_clear  = (state == IDLE);
    assign rc_enable = (state == LOAD) || round_en;

    skinny_rc_lfsr #(
        .RC_W (RC_W)
    ) u_rc_lfsr (
        .clock  (clock),
        .reset  (reset),
        .clear  (rc_clear),
        .enable (rc_enable),
        .rc     (rc)
    );

endmodule

// File: tb/tb_skinny_round_ctrl.sv
// Directed bench for skinny_round_ctrl: reset, rc sequence, latency, stalls,
// ignored starts, mid-run reset and ack/start collision.
module tb_skinny_round_ctrl;

    logic       clock;
    logic       reset;
    logic       start;
    logic       hold;
    logic       ack;
    logic       load;
    logic       round_en;
    logic       tk_en;
    logic [5:0] rc;
    logic [5:0] round_idx;
    logic       last_round;
    logic       busy;
    logic       valid;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] RC_REF [10] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F,
                                           6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F};

    // Observations gathered by run()
    int         obs_latency;
    int         obs_load_cnt;
    int         obs_load_bad;
    int         obs_rounds;
    int         obs_last_cnt;
    int         obs_last_idx;
    int         obs_excl;
    int         obs_seq_bad;
    int         obs_max_idx;
    int         obs_frozen_cnt;
    int         obs_frozen_bad;
    logic [5:0] obs_rc [10];

    skinny_round_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .hold       (hold),
        .ack        (ack),
        .load       (load),
        .round_en   (round_en),
        .tk_en      (tk_en),
        .rc         (rc),
        .round_idx  (round_idx),
        .last_round (last_round),
        .busy       (busy),
        .valid      (valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [5:0] rc_model(input int updates);
        logic [5:0] r;
        r = 6'h00;
        for (int i = 0; i < updates; i++) r = {r[4:0], r[5] ^ r[4] ^ 1'b1};
        return r;
    endfunction

    // Caller sits at a negedge in IDLE; start is raised immediately. Returns once valid is seen.
    task automatic run(input int hold_idx, input int hold_len, input bit start_mid);
        int cyc;
        int held;
        int exp_idx;
        bit done;
        bit mid_done;
        obs_latency = -1; obs_load_cnt = 0; obs_load_bad = 0; obs_rounds = 0;
        obs_last_cnt = 0; obs_last_idx = -1; obs_excl = 0; obs_seq_bad = 0;
        obs_max_idx = 0; obs_frozen_cnt = 0; obs_frozen_bad = 0;
        for (int i = 0; i < 10; i++) obs_rc[i] = 6'hXX;
        cyc = 0; held = 0; exp_idx = 0; done = 1'b0; mid_done = 1'b0;
        start = 1'b1;
        while (!done && cyc < 200) begin
            @(negedge clock);
            cyc++;
            start = 1'b0;
            hold  = 1'b0;
            if (start_mid && !mid_done && busy && !load && round_idx == 6'd10) begin
                start = 1'b1;
                mid_done = 1'b1;
            end
            if (hold_idx >= 0 && busy && !load && int'(round_idx) == hold_idx && held < hold_len) begin
                hold = 1'b1;
                held++;
            end
            #1;
            if (int'(load) + int'(round_en) + int'(valid) > 1) obs_excl++;
            if (tk_en !== round_en) obs_excl++;
            if (int'(round_idx) > obs_max_idx) obs_max_idx = int'(round_idx);
            if (load) begin
                obs_load_cnt++;
                if (rc !== 6'h00 || round_idx !== 6'd0) obs_load_bad++;
            end
            if (hold) begin
                obs_frozen_cnt++;
                if (round_en || int'(round_idx) != hold_idx || rc !== rc_model(hold_idx + 1))
                    obs_frozen_bad++;
            end
            if (round_en) begin
                obs_rounds++;
                if (int'(round_idx) != exp_idx || rc !== rc_model(exp_idx + 1)) obs_seq_bad++;
                if (round_idx < 6'd10) obs_rc[round_idx] = rc;
                exp_idx++;
            end
            if (last_round) begin
                obs_last_cnt++;
                obs_last_idx = int'(round_idx);
            end
            if (valid) begin
                obs_latency = cyc - 1;
                done = 1'b1;
            end
        end
        hold  = 1'b0;
        start = 1'b0;
    endtask

    task automatic do_ack;
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; hold = 1'b0; ack = 1'b0;
        #2;
        checks++;
        if ({load, round_en, tk_en, rc, round_idx, last_round, busy, valid} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {load, round_en, tk_en, rc, round_idx, last_round, busy, valid});
        end
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if ({load, busy, valid, rc, round_idx} !== 15'd0) begin
            errors++;
            $display("FAIL reset_held_with_start: got %h expected 0", {load, busy, valid, rc, round_idx});
        end
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || load !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b load=%b expected 0", busy, load);
        end
        @(negedge clock);
    endtask

    task automatic test_basic_run;
        run(-1, 0, 1'b0);
        checks++;
        if (obs_load_cnt !== 1 || obs_load_bad !== 0) begin
            errors++;
            $display("FAIL load_cycle: got count=%0d bad=%0d expected 1/0", obs_load_cnt, obs_load_bad);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs_rc[i] !== RC_REF[i]) begin
                errors++;
                $display("FAIL rc_round%0d: got %h expected %h", i, obs_rc[i], RC_REF[i]);
            end
        end
        checks++;
        if (obs_latency !== 57) begin
            errors++;
            $display("FAIL latency: got %0d expected 57", obs_latency);
        end
        checks++;
        if (obs_last_cnt !== 1 || obs_last_idx !== 55) begin
            errors++;
            $display("FAIL last_round: got count=%0d idx=%0d expected 1/55", obs_last_cnt, obs_last_idx);
        end
        checks++;
        if (obs_rounds !== 56 || obs_seq_bad !== 0 || obs_max_idx !== 55) begin
            errors++;
            $display("FAIL round_sequence: got rounds=%0d bad=%0d max=%0d expected 56/0/55",
                     obs_rounds, obs_seq_bad, obs_max_idx);
        end
        checks++;
        if (obs_excl !== 0) begin
            errors++;
            $display("FAIL exclusivity: got %0d violations expected 0", obs_excl);
        end
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (valid !== 1'b1 || busy !== 1'b0 || round_idx !== 6'd55) begin
            errors++;
            $display("FAIL done_hold: got valid=%b busy=%b idx=%0d expected 1/0/55", valid, busy, round_idx);
        end
        do_ack();
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || round_idx !== 6'd0) begin
            errors++;
            $display("FAIL ack_to_idle: got valid=%b busy=%b idx=%0d expected 0/0/0", valid, busy, round_idx);
        end
    endtask

    task automatic test_hold;
        @(negedge clock);
        run(20, 3, 1'b0);
        checks++;
        if (obs_frozen_cnt !== 3 || obs_frozen_bad !== 0) begin
            errors++;
            $display("FAIL hold_freeze: got cycles=%0d bad=%0d expected 3/0", obs_frozen_cnt, obs_frozen_bad);
        end
        checks++;
        if (obs_latency !== 60) begin
            errors++;
            $display("FAIL hold_latency: got %0d expected 60", obs_latency);
        end
        checks++;
        if (obs_rounds !== 56 || obs_seq_bad !== 0 || obs_excl !== 0) begin
            errors++;
            $display("FAIL hold_sequence: got rounds=%0d bad=%0d excl=%0d expected 56/0/0",
                     obs_rounds, obs_seq_bad, obs_excl);
        end
        do_ack();
    endtask

    task automatic test_ignored_start;
        int extra;
        @(negedge clock);
        run(-1, 0, 1'b1);
        checks++;
        if (obs_load_cnt !== 1 || obs_latency !== 57 || obs_seq_bad !== 0) begin
            errors++;
            $display("FAIL start_mid_run: got loads=%0d latency=%0d bad=%0d expected 1/57/0",
                     obs_load_cnt, obs_latency, obs_seq_bad);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: got valid=%b busy=%b expected 1/0", valid, busy);
        end
        do_ack();
        extra = 0;
        repeat (5) begin
            if (busy || load || valid) extra++;
            @(negedge clock);
            #1;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL no_queued_start: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_reset_mid_round;
        bit found;
        found = 1'b0;
        @(negedge clock);
        start = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            start = 1'b0;
            #1;
            if (busy && !load && round_idx == 6'd30) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_round30: got timeout expected round_idx=30");
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({load, round_en, tk_en, rc, round_idx, last_round, busy, valid} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0",
                     {load, round_en, tk_en, rc, round_idx, last_round, busy, valid});
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run(-1, 0, 1'b0);
        checks++;
        if (obs_rc[0] !== 6'h01 || obs_load_bad !== 0 || obs_latency !== 57 || obs_seq_bad !== 0) begin
            errors++;
            $display("FAIL clean_rerun: got rc0=%h loadbad=%0d latency=%0d bad=%0d expected 01/0/57/0",
                     obs_rc[0], obs_load_bad, obs_latency, obs_seq_bad);
        end
        do_ack();
    endtask

    task automatic test_back_to_back;
        @(negedge clock);
        run(-1, 0, 1'b0);
        ack = 1'b1;
        start = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || load !== 1'b0) begin
            errors++;
            $display("FAIL ack_start_same_cycle: got valid=%b busy=%b load=%b expected 0/0/0",
                     valid, busy, load);
        end
        run(-1, 0, 1'b0);
        checks++;
        if (obs_load_cnt !== 1 || obs_latency !== 57 || obs_seq_bad !== 0 || obs_last_idx !== 55) begin
            errors++;
            $display("FAIL second_run: got loads=%0d latency=%0d bad=%0d last=%0d expected 1/57/0/55",
                     obs_load_cnt, obs_latency, obs_seq_bad, obs_last_idx);
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_hold();
        test_ignored_start();
        test_reset_mid_round();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/skinny_round_ctrl.md
SKINNY_ROUND_CTRL -- requirements
Module: skinny_round_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 56, total round iterations (SKINNY-128-384).
REQ-002 SHALL have parameter RC_W, default 6, round-constant width.
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request one encryption; sampled only in IDLE.
REQ-006 SHALL have port hold  input  1  freeze round progress (shared-datapath stall).
REQ-007 SHALL have port ack  input  1  consumer has taken the result.
REQ-008 SHALL have port load  output  1  load plaintext and tweakey registers.
REQ-009 SHALL have port round_en  output  1  datapath performs one round this cycle.
REQ-010 SHALL have port tk_en  output  1  tweakey schedule advances this cycle; equals round_en.
REQ-011 SHALL have port rc  output  RC_W  round constant for the current round.
REQ-012 SHALL have port round_idx  output  6  index of the current round, 0..NUM_ROUNDS-1.
REQ-013 SHALL have port last_round  output  1  round_en is active for round NUM_ROUNDS-1.
REQ-014 SHALL have port busy  output  1  high in LOAD and ROUND.
REQ-015 SHALL have port valid  output  1  ciphertext register holds the final result.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, ROUND, DONE.
REQ-017 IDLE->LOAD SHALL occur when start=1; start in any other state SHALL be ignored, not queued.
REQ-018 LOAD SHALL last exactly one cycle with load=1, round_idx=0, rc=6'h00, then go to ROUND regardless of hold.
REQ-019 In ROUND with hold=0, round_en=tk_en=1; round_idx and rc SHALL advance at the clock edge.
REQ-020 In ROUND with hold=1, round_en=tk_en=0; round_idx and rc SHALL hold their values.
REQ-021 rc SHALL be driven from a 6-bit LFSR: zeroed in LOAD; the value presented in round r is the register after r+1 updates, each update being {rc[4:0], rc[5]^rc[4]^1}; round 0 sees 6'h01.
REQ-022 last_round SHALL equal round_en AND (round_idx==NUM_ROUNDS-1); on that edge ROUND->DONE.
REQ-023 Unstalled latency SHALL be 1+NUM_ROUNDS cycles from the start-sampling edge to valid=1 (57 cycles at default).
REQ-024 DONE SHALL hold valid=1 until ack=1; ack=1 in DONE returns the FSM to IDLE on that edge.
REQ-025 ack=1 and start=1 in the same DONE cycle SHALL go to IDLE only; a new start is accepted in a later IDLE cycle.
REQ-026 ack outside DONE and hold outside ROUND SHALL have no effect.
REQ-027 load, round_en, tk_en, last_round and valid SHALL be mutually consistent: at most one of load, round_en, valid high per cycle.
REQ-028 round_idx SHALL never exceed NUM_ROUNDS-1 and SHALL not wrap within a run.

Reset
REQ-029 reset=1 SHALL force IDLE immediately, asynchronously, from any state including mid-ROUND.
REQ-030 During and after reset: load=0, round_en=0, tk_en=0, rc=0, round_idx=0, last_round=0, busy=0, valid=0.
REQ-031 After reset deasserts, the first start SHALL begin a clean run with no residue from the aborted run.

Structure
REQ-032 A shared package skinny_pkg SHALL hold NUM_ROUNDS, RC_W, the FSM state enum and the RC_INIT constant.
REQ-033 The round-constant LFSR SHALL be one sub-module, skinny_rc_lfsr (clear, enable, rc out).
REQ-034 The controller SHALL contain no datapath (S-box, MixColumns, tweakey permutation) logic.

Verification
REQ-035 Start pulse after reset -> load for 1 cycle, then rc sequence 01,03,07,0F,1F,3E,3D,3B,37,2F on rounds 0..9.
REQ-036 Start with hold=0 -> valid rises exactly 57 cycles after start sampled; last_round high on round_idx=55 only.
REQ-037 hold=1 for 3 cycles at round_idx=20 -> round_idx/rc frozen 3 cycles, valid delayed to cycle 60.
REQ-038 start pulses at round 10 and in DONE before ack -> ignored; exactly one run, one valid.
REQ-039 reset asserted at round_idx=30 -> all outputs 0 immediately; next start yields rc=01 at round 0 and valid at 57.
REQ-040 ack and start together in DONE -> IDLE, valid=0 next cycle; start one cycle later -> new run completes normally.
